mux4_frame_serializer: RTL and testbench

//   Upstream sequencer for the 4:1 mux. Accepts 4-bit parallel words on a

---
 rtl/mux4_frame_serializer_pkg.sv | 20 ++
 rtl/mux4_frame_serializer_mux.sv | 14 +
 rtl/mux4_frame_serializer.sv | 119 +++++++++++
 tb/tb_mux4_frame_serializer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_frame_serializer_pkg.sv
// Shared types, sizes and select mapping for the 4-bit frame serializer.
package mux4_frame_serializer_pkg;

    localparam int unsigned FRAME_BITS = 4;
    localparam int unsigned SEL_W      = 2;

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } state_e;

    // Map the bit counter to the mux input index for the chosen bit order.
    function automatic logic [SEL_W-1:0] frame_idx(input logic [SEL_W-1:0] cnt,
                                                   input logic msb_first);
        logic [SEL_W-1:0] last;
        last = SEL_W'(FRAME_BITS - 1);
        return msb_first ? (last - cnt) : cnt;
    endfunction

endpackage

// File: rtl/mux4_frame_serializer_mux.sv
// Plain 4:1 mux; y follows the data input picked by {s1,s0}.
module mux4_frame_serializer_mux (
    input  logic       s0,
    input  logic       s1,
    input  logic [3:0] d,
    output logic       y
);

    // Select one of four data inputs.
    always_comb begin
        y = d[{s1, s0}];
    end

endmodule

// File: rtl/mux4_frame_serializer.sv
// Serializes 4-bit words through a 4:1 mux by stepping its selects, with a
// one-entry holding buffer so consecutive frames run without idle cycles.
module mux4_frame_serializer
    import mux4_frame_serializer_pkg::*;
#(
    parameter bit   MSB_FIRST  = 1'b0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FRAME_BITS-1:0] in_data,
    output logic                  s0,
    output logic                  s1,
    output logic [FRAME_BITS-1:0] d,
    output logic                  ser_bit,
    output logic                  ser_valid,
    output logic                  ser_sof,
    output logic                  ser_eof,
    output logic                  busy
);

    localparam logic [FRAME_BITS-1:0] IdleWord = {FRAME_BITS{IDLE_LEVEL}};
    localparam logic [SEL_W-1:0]      LastCnt  = SEL_W'(FRAME_BITS - 1);

    state_e                state_q, state_d;
    logic [SEL_W-1:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [FRAME_BITS-1:0] cur_q, cur_d;
    logic [FRAME_BITS-1:0] nxt_q, nxt_d;
    logic                  nxt_full_q, nxt_full_d;
    logic                  accept;

    // State register: FSM, bit counter, word registers and registered selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sel_q      <= frame_idx('0, MSB_FIRST);
            cur_q      <= IdleWord;
            nxt_q      <= '0;
            nxt_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            cur_q      <= cur_d;
            nxt_q      <= nxt_d;
            nxt_full_q <= nxt_full_d;
        end
    end

    // Next-state: frame sequencing, buffer fill/drain and direct reload at frame end.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        nxt_d      = nxt_q;
        nxt_full_d = nxt_full_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cur_d   = in_data;
                    cnt_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (cnt_q != LastCnt) begin
                    cnt_d = cnt_q + SEL_W'(1);
                    if (accept) begin
                        nxt_d      = in_data;
                        nxt_full_d = 1'b1;
                    end
                end else if (nxt_full_q) begin
                    cur_d      = nxt_q;
                    cnt_d      = '0;
                    nxt_full_d = accept;
                    if (accept) begin
                        nxt_d = in_data;
                    end
                end else if (accept) begin
                    // Empty buffer at the last bit: load straight into the frame.
                    cur_d = in_data;
                    cnt_d = '0;
                end else begin
                    state_d = StIdle;
                    cur_d   = IdleWord;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
        // Selects are registered alongside the counter so they line up with it.
        sel_d = frame_idx(cnt_d, MSB_FIRST);
    end

    // Outputs: handshake, framing flags and mux drive, all from registered state.
    always_comb begin
        in_ready  = !rst && !nxt_full_q;
        accept    = in_valid && in_ready;
        ser_valid = (state_q == StSend);
        ser_sof   = (state_q == StSend) && (cnt_q == '0);
        ser_eof   = (state_q == StSend) && (cnt_q == LastCnt);
        busy      = (state_q == StSend) || nxt_full_q;
        s0        = sel_q[0];
        s1        = sel_q[1];
        d         = cur_q;
    end

    mux4_frame_serializer_mux u_mux (
        .s0 (s0),
        .s1 (s1),
        .d  (cur_q),
        .y  (ser_bit)
    );

endmodule

// File: tb/tb_mux4_frame_serializer.sv
// Bench for mux4_frame_serializer: LSB-first and MSB-first instances share stimulus
// and are checked each cycle against a word-queue reference model.
module tb_mux4_frame_serializer;

    logic       clk, rst, in_valid;
    logic [3:0] in_data;

    logic       in_ready0, s0_0, s1_0, ser_bit0, ser_valid0, ser_sof0, ser_eof0, busy0;
    logic [3:0] d0;
    logic       in_ready1, s0_1, s1_1, ser_bit1, ser_valid1, ser_sof1, ser_eof1, busy1;
    logic [3:0] d1;

    int n_checks = 0;
    int n_pass   = 0;

    mux4_frame_serializer #(.MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .s0(s0_0), .s1(s1_0), .d(d0), .ser_bit(ser_bit0), .ser_valid(ser_valid0),
        .ser_sof(ser_sof0), .ser_eof(ser_eof0), .busy(busy0)
    );

    mux4_frame_serializer #(.MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .s0(s0_1), .s1(s1_1), .d(d1), .ser_bit(ser_bit1), .ser_valid(ser_valid1),
        .ser_sof(ser_sof1), .ser_eof(ser_eof1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: current frame word and bit position, plus pending words.
    bit         m_active = 1'b0;
    logic [3:0] m_cur = 4'h0;
    int         m_b = 0;
    logic [3:0] m_pend[$];
    logic [3:0] m_done[$];
    logic [3:0] m_acc[$];
    logic [3:0] got0[$];
    logic [3:0] got1[$];

    function automatic logic m_ready();
        return !rst && (m_pend.size() == 0);
    endfunction

    task automatic model_edge();
        logic acc;
        acc = in_valid && m_ready();
        if (rst) begin
            m_active = 1'b0;
            m_b = 0;
            m_pend.delete();
        end else begin
            if (acc) m_acc.push_back(in_data);
            if (!m_active) begin
                if (acc) begin
                    m_active = 1'b1;
                    m_cur = in_data;
                    m_b = 0;
                end
            end else if (m_b < 3) begin
                m_b++;
                if (acc) m_pend.push_back(in_data);
            end else begin
                m_done.push_back(m_cur);
                if (m_pend.size() > 0) begin
                    m_cur = m_pend.pop_front();
                    m_b = 0;
                end else if (acc) begin
                    m_cur = in_data;
                    m_b = 0;
                end else begin
                    m_active = 1'b0;
                end
            end
        end
    endtask

    // Expected {ready,valid,sof,eof,bit,busy,s1,s0,d[3:0]}.
    function automatic logic [11:0] exp_vec(input bit msb);
        logic [1:0] sel;
        sel = m_active ? (msb ? 2'(3 - m_b) : 2'(m_b)) : (msb ? 2'd3 : 2'd0);
        return {m_ready(), m_active, m_active && (m_b == 0), m_active && (m_b == 3),
                m_active ? m_cur[sel] : 1'b0, m_active || (m_pend.size() > 0), sel,
                m_active ? m_cur : 4'h0};
    endfunction

    function automatic logic [11:0] obs0();
        return {in_ready0, ser_valid0, ser_sof0, ser_eof0, ser_bit0, busy0, s1_0, s0_0, d0};
    endfunction

    function automatic logic [11:0] obs1();
        return {in_ready1, ser_valid1, ser_sof1, ser_eof1, ser_bit1, busy1, s1_1, s0_1, d1};
    endfunction

    // Reassemble emitted frames from the serial streams.
    logic [3:0] acc0, acc1;
    int         k0, k1;
    always @(negedge clk) begin
        if (!rst && ser_valid0 === 1'b1) begin
            if (ser_sof0) begin acc0 = 4'h0; k0 = 0; end
            acc0[k0[1:0]] = ser_bit0;
            k0++;
            if (ser_eof0) got0.push_back(acc0);
        end
        if (!rst && ser_valid1 === 1'b1) begin
            if (ser_sof1) begin acc1 = 4'h0; k1 = 0; end
            acc1[2'(3 - k1)] = ser_bit1;
            k1++;
            if (ser_eof1) got1.push_back(acc1);
        end
    end

    task automatic drive(input logic v, input logic [3:0] x, input logic r);
        in_valid = v;
        in_data  = x;
        rst      = r;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_sb();
        got0.delete(); got1.delete(); m_done.delete(); m_acc.delete();
    endtask

    task automatic test_reset();
        drive(1'b1, 4'hF, 1'b1);
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom), 1'b1);
            n_checks += 2;
            if (obs0() !== 12'h000) $display("FAIL reset dut0: got %h want 000", obs0());
            else n_pass++;
            if (obs1() !== 12'h030) $display("FAIL reset dut1: got %h want 030", obs1());
            else n_pass++;
            advance();
        end
    endtask

    task automatic test_single();
        clear_sb();
        for (int i = 0; i < 8; i++) begin
            drive(i == 0, (i == 0) ? 4'b1011 : 4'($urandom), 1'b0);
            n_checks += 2;
            if (obs0() !== exp_vec(0)) $display("FAIL single dut0: got %h want %h", obs0(), exp_vec(0));
            else n_pass++;
            if (obs1() !== exp_vec(1)) $display("FAIL single dut1: got %h want %h", obs1(), exp_vec(1));
            else n_pass++;
            advance();
        end
        n_checks += 2;
        if (got0.size() != 1 || got0[0] !== 4'b1011)
            $display("FAIL single_word dut0: got %0d words first %h want 1 word b", got0.size(), got0[0]);
        else n_pass++;
        if (got1.size() != 1 || got1[0] !== 4'b1011)
            $display("FAIL single_word dut1: got %0d words first %h want 1 word b", got1.size(), got1[0]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_sb();
        for (int i = 0; i < 12; i++) begin
            drive(i < 2, (i == 0) ? 4'hA : 4'h5, 1'b0);
            n_checks += 2;
            if (obs0() !== exp_vec(0)) $display("FAIL b2b dut0: got %h want %h", obs0(), exp_vec(0));
            else n_pass++;
            if (obs1() !== exp_vec(1)) $display("FAIL b2b dut1: got %h want %h", obs1(), exp_vec(1));
            else n_pass++;
            advance();
        end
        n_checks++;
        if (got0.size() != 2 || got0[0] !== 4'hA || got0[1] !== 4'h5)
            $display("FAIL b2b_order dut0: got %0d words, want A then 5", got0.size());
        else n_pass++;
    endtask

    task automatic test_msb();
        clear_sb();
        drive(1'b1, 4'b0001, 1'b0);
        advance();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 4'h0, 1'b0);
            n_checks += 2;
            if ({s1_1, s0_1} !== 2'(3 - k))
                $display("FAIL msb_sel step %0d: got %0d want %0d", k, {s1_1, s0_1}, 3 - k);
            else n_pass++;
            if (ser_bit1 !== (k == 3))
                $display("FAIL msb_bit step %0d: got %b want %b", k, ser_bit1, k == 3);
            else n_pass++;
            advance();
        end
    endtask

    task automatic test_direct_load();
        for (int i = 0; i < 7; i++) begin
            drive(i == 0 || i == 4, (i == 0) ? 4'h6 : 4'h9, 1'b0);
            n_checks += 2;
            if (obs0() !== exp_vec(0)) $display("FAIL direct dut0: got %h want %h", obs0(), exp_vec(0));
            else n_pass++;
            if (obs1() !== exp_vec(1)) $display("FAIL direct dut1: got %h want %h", obs1(), exp_vec(1));
            else n_pass++;
            if (i == 5) begin
                n_checks++;
                if (ser_sof0 !== 1'b1 || in_ready0 !== 1'b1 || d0 !== 4'h9)
                    $display("FAIL direct_sof: got sof %b ready %b d %h want 1 1 9",
                             ser_sof0, in_ready0, d0);
                else n_pass++;
            end
            advance();
        end
        repeat (4) begin drive(1'b0, 4'h0, 1'b0); advance(); end
    endtask

    task automatic test_reset_mid();
        clear_sb();
        // i=0 accept, i=1 buffer, i=3 reset at cnt==2, i=4 reset held, then idle.
        for (int i = 0; i < 11; i++) begin
            drive(i < 2, (i == 0) ? 4'hC : 4'h3, i == 3 || i == 4);
            n_checks += 2;
            if (obs0() !== exp_vec(0)) $display("FAIL rstmid dut0: got %h want %h", obs0(), exp_vec(0));
            else n_pass++;
            if (obs1() !== exp_vec(1)) $display("FAIL rstmid dut1: got %h want %h", obs1(), exp_vec(1));
            else n_pass++;
            if (i == 4) begin
                n_checks++;
                if (obs0() !== 12'h000) $display("FAIL rstmid_clear: got %h want 000", obs0());
                else n_pass++;
            end
            advance();
        end
        n_checks += 2;
        if (got0.size() != 0) $display("FAIL rstmid_emit dut0: got %0d words want 0", got0.size());
        else n_pass++;
        if (got1.size() != 0) $display("FAIL rstmid_emit dut1: got %0d words want 0", got1.size());
        else n_pass++;
    endtask

    task automatic test_random();
        clear_sb();
        for (int i = 0; i < 170; i++) begin
            drive((i < 160) ? 1'($urandom_range(0, 1)) : 1'b0, 4'($urandom), 1'b0);
            n_checks += 2;
            if (obs0() !== exp_vec(0)) $display("FAIL random dut0 cyc %0d: got %h want %h", i, obs0(), exp_vec(0));
            else n_pass++;
            if (obs1() !== exp_vec(1)) $display("FAIL random dut1 cyc %0d: got %h want %h", i, obs1(), exp_vec(1));
            else n_pass++;
            advance();
        end
        n_checks += 2;
        if (got0.size() != m_acc.size())
            $display("FAIL random_count dut0: got %0d words want %0d", got0.size(), m_acc.size());
        else n_pass++;
        if (got1.size() != m_acc.size())
            $display("FAIL random_count dut1: got %0d words want %0d", got1.size(), m_acc.size());
        else n_pass++;
        for (int i = 0; i < m_acc.size() && i < got0.size() && i < got1.size(); i++) begin
            n_checks += 2;
            if (got0[i] !== m_acc[i]) $display("FAIL random_word dut0 #%0d: got %h want %h", i, got0[i], m_acc[i]);
            else n_pass++;
            if (got1[i] !== m_acc[i]) $display("FAIL random_word dut1 #%0d: got %h want %h", i, got1[i], m_acc[i]);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 4'h0;
        test_reset();
        test_single();
        test_back_to_back();
        test_msb();
        test_direct_load();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
